// File: rtl/traffic_mon_pkg.sv
// Shared encodings for the traffic light monitor: light codes, approach
// indices, tracker phases and fault cause codes.
package traffic_mon_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    localparam logic [1:0] DIR_S = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_N = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    localparam logic [2:0] FLT_NONE        = 3'd0;
    localparam logic [2:0] FLT_BAD_CODE    = 3'd1;
    localparam logic [2:0] FLT_BAD_SEQ     = 3'd2;
    localparam logic [2:0] FLT_CONFLICT    = 3'd3;
    localparam logic [2:0] FLT_GREEN_TIME  = 3'd4;
    localparam logic [2:0] FLT_YELLOW_TIME = 3'd5;
    localparam logic [2:0] FLT_ORDER       = 3'd6;
    localparam logic [2:0] FLT_ALLRED      = 3'd7;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/traffic_phase_tracker.sv
// Follows one approach's light through RED/GREEN/YELLOW and flags encoding,
// sequencing and dwell-time violations for the sample currently presented.
module traffic_phase_tracker
    import traffic_mon_pkg::*;
#(
    parameter int GREEN_MIN     = 4,
    parameter int GREEN_MAX     = 12,
    parameter int YELLOW_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    output phase_t     state,
    output logic [7:0] dwell,
    output logic       entered_green,
    output logic       bad_code,
    output logic       bad_seq,
    output logic       green_time_err,
    output logic       yellow_time_err
);

    phase_t     state_reg, state_next, sample_phase;
    logic [7:0] dwell_reg, dwell_next;
    logic       code_ok;

    always_comb begin
        sample_phase = state_reg;
        code_ok      = 1'b1;
        case (light)
            LT_RED:  sample_phase = PH_RED;
            LT_GRN:  sample_phase = PH_GREEN;
            LT_YEL:  sample_phase = PH_YELLOW;
            default: code_ok = 1'b0;
        endcase
    end

    // A malformed sample leaves the tracker untouched and raises only bad_code.
    always_comb begin
        state_next      = state_reg;
        dwell_next      = dwell_reg;
        bad_code        = ~code_ok;
        bad_seq         = 1'b0;
        entered_green   = 1'b0;
        green_time_err  = 1'b0;
        yellow_time_err = 1'b0;
        if (code_ok) begin
            if (sample_phase == state_reg) begin
                dwell_next = sat_inc8(dwell_reg);
            end else begin
                state_next = sample_phase;
                dwell_next = 8'd1;
            end
            bad_seq = (state_reg == PH_RED    && sample_phase == PH_YELLOW) ||
                      (state_reg == PH_GREEN  && sample_phase == PH_RED)    ||
                      (state_reg == PH_YELLOW && sample_phase == PH_GREEN);
            entered_green = (state_reg == PH_RED) && (sample_phase == PH_GREEN);
            green_time_err = (state_reg == PH_GREEN) &&
                ((sample_phase == PH_YELLOW && dwell_reg < 8'(GREEN_MIN)) ||
                 (sample_phase == PH_GREEN  && dwell_reg == 8'(GREEN_MAX)));
            yellow_time_err = (state_reg == PH_YELLOW) &&
                ((sample_phase == PH_RED    && dwell_reg != 8'(YELLOW_CYCLES)) ||
                 (sample_phase == PH_YELLOW && dwell_reg == 8'(YELLOW_CYCLES)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= PH_RED;
            dwell_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            dwell_reg <= dwell_next;
        end
    end

    assign state = state_reg;
    assign dwell = dwell_reg;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the four light buses: cross-approach checks, fault
// priority and latching, active approach reporting and rotation counting.
module traffic_light_monitor
    import traffic_mon_pkg::*;
#(
    parameter int GREEN_MIN     = 4,
    parameter int GREEN_MAX     = 12,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_MAX    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_S,
    input  logic [2:0] light_E,
    input  logic [2:0] light_N,
    input  logic [2:0] light_W,
    input  logic       clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic [1:0] active_dir,
    output logic       active_valid,
    output logic [7:0] rotations
);

    logic [2:0] light_arr [4];
    phase_t     trk_state [4];
    logic [7:0] trk_dwell [4];
    logic [3:0] trk_unused;
    logic [3:0] entered_green, bad_code, bad_seq, green_time_err, yellow_time_err;
    logic [3:0] non_red, order_err;

    logic       fault_reg, fault_next, active_valid_reg, active_valid_next;
    logic [2:0] fault_code_reg, fault_code_next;
    logic [1:0] fault_dir_reg, fault_dir_next, active_dir_reg, active_dir_next;
    logic [1:0] prev_green_reg, prev_green_next;
    logic       prev_valid_reg, prev_valid_next;
    logic [7:0] rotations_reg, rotations_next, allred_cnt_reg, allred_cnt_next;

    logic       all_red, allred_hit, conflict, new_fault;
    logic [2:0] new_code;
    logic [1:0] new_dir, onehot_idx;
    logic [3:0] flt_vec [8];

    assign light_arr[DIR_S] = light_S;
    assign light_arr[DIR_E] = light_E;
    assign light_arr[DIR_N] = light_N;
    assign light_arr[DIR_W] = light_W;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_trk
            traffic_phase_tracker #(
                .GREEN_MIN     (GREEN_MIN),
                .GREEN_MAX     (GREEN_MAX),
                .YELLOW_CYCLES (YELLOW_CYCLES)
            ) u_trk (
                .clk             (clk),
                .rst             (rst),
                .light           (light_arr[gi]),
                .state           (trk_state[gi]),
                .dwell           (trk_dwell[gi]),
                .entered_green   (entered_green[gi]),
                .bad_code        (bad_code[gi]),
                .bad_seq         (bad_seq[gi]),
                .green_time_err  (green_time_err[gi]),
                .yellow_time_err (yellow_time_err[gi])
            );
            assign trk_unused[gi] = ^{trk_state[gi], trk_dwell[gi]};
            assign non_red[gi]    = (light_arr[gi] != LT_RED);
            assign order_err[gi]  = entered_green[gi] && prev_valid_reg &&
                                    (2'(gi) != 2'(prev_green_reg + 2'd1));
        end
    endgenerate

    assign all_red    = ~|non_red;
    assign allred_hit = all_red && (allred_cnt_reg == 8'(ALLRED_MAX));
    assign conflict   = ($countones(non_red) > 1);

    // Scanning from highest code/direction down lets the lowest code, then the
    // lowest direction, overwrite last.
    always_comb begin
        flt_vec[0] = 4'b0000;
        flt_vec[1] = bad_code;
        flt_vec[2] = bad_seq;
        flt_vec[3] = conflict ? non_red : 4'b0000;
        flt_vec[4] = green_time_err;
        flt_vec[5] = yellow_time_err;
        flt_vec[6] = order_err;
        flt_vec[7] = {3'b000, allred_hit};
        new_fault  = 1'b0;
        new_code   = FLT_NONE;
        new_dir    = DIR_S;
        for (int c = 7; c >= 1; c--) begin
            for (int d = 3; d >= 0; d--) begin
                if (flt_vec[c][d]) begin
                    new_fault = 1'b1;
                    new_code  = 3'(c);
                    new_dir   = 2'(d);
                end
            end
        end
    end

    always_comb begin
        prev_green_next = prev_green_reg;
        prev_valid_next = prev_valid_reg;
        onehot_idx      = DIR_S;
        for (int d = 3; d >= 0; d--) begin
            if (entered_green[d]) begin
                prev_green_next = 2'(d);
                prev_valid_next = 1'b1;
            end
            if (non_red[d]) onehot_idx = 2'(d);
        end
        rotations_next = rotations_reg +
            ((entered_green[DIR_S] && prev_valid_reg && prev_green_reg == DIR_W) ? 8'd1 : 8'd0);
        allred_cnt_next   = all_red ? sat_inc8(allred_cnt_reg) : 8'd0;
        active_valid_next = $onehot(non_red);
        active_dir_next   = active_valid_next ? onehot_idx : active_dir_reg;

        fault_next      = fault_reg;
        fault_code_next = fault_code_reg;
        fault_dir_next  = fault_dir_reg;
        if (new_fault && (!fault_reg || clear)) begin
            fault_next      = 1'b1;
            fault_code_next = new_code;
            fault_dir_next  = new_dir;
        end else if (clear) begin
            fault_next      = 1'b0;
            fault_code_next = FLT_NONE;
            fault_dir_next  = DIR_S;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_reg        <= 1'b0;
            fault_code_reg   <= FLT_NONE;
            fault_dir_reg    <= DIR_S;
            active_dir_reg   <= DIR_S;
            active_valid_reg <= 1'b0;
            rotations_reg    <= 8'd0;
            prev_green_reg   <= DIR_S;
            prev_valid_reg   <= 1'b0;
            allred_cnt_reg   <= 8'd0;
        end else begin
            fault_reg        <= fault_next;
            fault_code_reg   <= fault_code_next;
            fault_dir_reg    <= fault_dir_next;
            active_dir_reg   <= active_dir_next;
            active_valid_reg <= active_valid_next;
            rotations_reg    <= rotations_next;
            prev_green_reg   <= prev_green_next;
            prev_valid_reg   <= prev_valid_next;
            allred_cnt_reg   <= allred_cnt_next;
        end
    end

    assign fault        = fault_reg;
    assign fault_code   = fault_code_reg;
    assign fault_dir    = fault_dir_reg;
    assign active_dir   = active_dir_reg;
    assign active_valid = active_valid_reg;
    assign rotations    = rotations_reg;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the receiving end of the four light buses (light_S/E/N/W) driven by the traffic light controller. It tracks each approach's phase, checks encoding, sequencing, dwell times, mutual exclusion and rotation order, and latches the first fault for the supervisor. It also reports the currently active approach and counts completed S->E->N->W rotations.

Parameters:
GREEN_MIN, 4, minimum legal green dwell in cycles
GREEN_MAX, 12, maximum legal green dwell in cycles
YELLOW_CYCLES, 2, exact required yellow dwell in cycles
ALLRED_MAX, 4, maximum consecutive cycles with all four approaches red

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
light_S  in  3  south light, one-hot {R,Y,G}: 100 red, 010 yellow, 001 green
light_E  in  3  east light, same encoding
light_N  in  3  north light, same encoding
light_W  in  3  west light, same encoding
clear  in  1  synchronous clear of the latched fault
fault  out  1  sticky fault flag
fault_code  out  3  cause of the latched fault
fault_dir  out  2  approach that caused it: 0 S, 1 E, 2 N, 3 W
active_dir  out  2  approach currently non-red
active_valid  out  1  exactly one approach is non-red
rotations  out  8  completed full rotations, wraps at 255

Behaviour:
- Reset (rst=0, async): fault=0, fault_code=0, fault_dir=0, active_dir=0, active_valid=0, rotations=0. All trackers go to RED with dwell 0. prev_valid=0. The all-red counter is cleared.
- Inputs are sampled every rising edge. All outputs are registered. A fault is visible immediately after the edge that sampled the offending value.
- Per-approach tracker FSM:
  - States are RED, GREEN and YELLOW.
  - Legal transitions: RED->GREEN, GREEN->YELLOW, YELLOW->RED, and self-loops.
  - The dwell counter is 8-bit saturating. It resets to 1 on entry to a state and increments on each repeat sample.
- Fault codes, in priority order (lowest number wins when several occur at once). For simultaneous faults on different approaches, the lowest fault_dir wins.
  - 1 BAD_CODE: the input is not one-hot (000, 011, 111, ...). The tracker state is unchanged.
  - 2 BAD_SEQ: an illegal transition (RED->YELLOW, GREEN->RED, YELLOW->GREEN). The tracker still moves to the new state.
  - 3 CONFLICT: more than one approach is non-red in the same sample.
  - 4 GREEN_TIME: raised when the GREEN->YELLOW exit happens with dwell < GREEN_MIN, or at the edge where the green dwell would reach GREEN_MAX+1.
  - 5 YELLOW_TIME: raised when the YELLOW->RED exit happens with dwell != YELLOW_CYCLES, or at the edge where the yellow dwell would reach YELLOW_CYCLES+1.
  - 6 ORDER: a new green approach is not (prev_green+1) mod 4. The check is only made when prev_valid=1. fault_dir reports the new approach.
  - 7 ALLRED: the all-red counter reaches ALLRED_MAX+1. fault_dir=0.
- Latching:
  - The first fault latches fault, fault_code and fault_dir. Later faults are ignored while fault=1.
  - clear=1 deasserts fault and zeros fault_code and fault_dir on the next edge.
  - If clear=1 and a new fault occur on the same edge, the new fault is latched.
- Trackers, the all-red counter and rotations keep running while a fault is latched.
- On each RED->GREEN entry: prev_green takes the new approach and prev_valid is set to 1.
- rotations increments on each legal W->S green handoff (prev_green=3, new green=S). It wraps 255->0.
- active_valid=1 and active_dir=index when exactly one approach is non-red. Otherwise active_valid=0 and active_dir holds its last value.
- The all-red counter is 8-bit saturating. It increments while all four approaches are RED and resets to 0 otherwise.
- Reset mid-operation returns the block to the reset state immediately, with no fault reported for the interrupted phase.

Decomposition:
- Package traffic_mon_pkg holds:
  - light encodings LT_RED, LT_YEL, LT_GRN
  - direction indices DIR_S..DIR_W
  - the phase state enum
  - fault code constants FLT_NONE..FLT_ALLRED
- Sub-module traffic_phase_tracker, instantiated four times, contains:
  - the state register and dwell counter
  - outputs for state, dwell, entered_green, bad_code, bad_seq, green_time_err and yellow_time_err
- The top level handles conflict, order, all-red, priority encoding, latching and rotation counting.

Test Plan:
- Legal rotation with each green lasting 6 cycles, yellow 2, and 1 all-red cycle between approaches, run for 2 full S->E->N->W loops -> fault=0 throughout; rotations=1 after the second S green; active_dir steps 0,1,2,3.
- light_E=3'b011 for one cycle during the S green -> fault=1, fault_code=1, fault_dir=1 on that edge; the latch holds after the input recovers.
- light_N goes directly from green to red (100) -> fault_code=2, fault_dir=2.
- S yellow held for 3 cycles -> fault_code=5, fault_dir=0 at the 3rd yellow edge. Then pulse clear -> fault=0. Then S green for 13 cycles -> fault_code=4 at the 13th green edge.
- S green while E is yellow in the same cycle -> fault_code=3. Separately, after S the next green is N -> fault_code=6, fault_dir=2.
- All red for 5 cycles -> fault_code=7 at the 5th edge. Then drive rst low mid-phase for 1 cycle -> all outputs 0 asynchronously, and a legal sequence afterwards raises no fault.
